trng_health_fifo: RTL and testbench

Downstream stage of the ring-oscillator TRNG wishbone wrapper. It samples each new 32-bit random word when the wrapper's `trng_valid`/`trng_buffer` pair presents one, and runs two online health tests on it: a repetition-count test and a per-word ones-count bound. Passing words go into a small first-word-fall-through FIFO that the secure-memory key logic drains. A health failure latches an alarm, flushes the FIFO and blocks output until firmware clears it.

---
 rtl/trng_health_fifo.sv | 200 ++++++++++++++++++++
 tb/tb_trng_health_fifo.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trng_health_fifo.sv
// trng_health_fifo: edge-captured TRNG words pass a repetition-count and
// ones-count health test, then enter a first-word-fall-through FIFO.
// A failure latches an alarm, flushes the FIFO and blocks output until cleared.
module trng_health_fifo #(
  parameter int unsigned WORD_WIDTH    = 32,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned STARTUP_WORDS = 2,
  parameter int unsigned RCT_LIMIT     = 3,
  parameter int unsigned ONES_MIN      = 8,
  parameter int unsigned ONES_MAX      = 24
) (
  input  logic                        wb_clk_i,
  input  logic                        rst_ni,
  input  logic                        enable_i,
  input  logic                        clear_i,
  input  logic                        trng_valid_i,
  input  logic [WORD_WIDTH-1:0]       trng_word_i,
  output logic                        data_valid_o,
  input  logic                        data_ready_i,
  output logic [WORD_WIDTH-1:0]       data_o,
  output logic [$clog2(FIFO_DEPTH):0] level_o,
  output logic                        health_fail_o,
  output logic [7:0]                  fail_cnt_o,
  output logic [7:0]                  drop_cnt_o
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(WORD_WIDTH + 1);
  localparam int unsigned RW = $clog2(RCT_LIMIT + 1);
  localparam int unsigned SW = (STARTUP_WORDS < 1) ? 1 : $clog2(STARTUP_WORDS + 1);

  typedef enum logic [1:0] {ST_STARTUP, ST_RUN, ST_FAIL} state_e;

  state_e                state_q, state_d;
  logic                  valid_q, pend_q, pend_d;
  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic [WORD_WIDTH-1:0] last_word_q, last_word_d;
  logic                  last_ok_q, last_ok_d;
  logic [RW-1:0]         rep_cnt_q, rep_cnt_d, rep_new;
  logic [SW-1:0]         su_cnt_q, su_cnt_d;
  logic [7:0]            fail_cnt_q, fail_cnt_d, drop_cnt_q, drop_cnt_d;
  logic [WORD_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;

  logic          active, cap, test, pc_fail, fail, pass;
  logic          push, pop, drop, flush, enter_su, full;
  logic [CW-1:0] pop_cnt;

  // Capture, health test, FSM next state and FIFO control
  always_comb begin
    active   = enable_i && (state_q != ST_FAIL);
    cap      = active && trng_valid_i && !valid_q;
    pend_d   = cap;
    word_d   = cap ? trng_word_i : word_q;
    // A word still pending when enable drops is abandoned untested.
    test     = pend_q && active;
    full     = (level_q == LW'(FIFO_DEPTH));
    pop      = (level_q != '0) && data_ready_i;

    pop_cnt = '0;
    for (int unsigned i = 0; i < WORD_WIDTH; i++) pop_cnt = pop_cnt + CW'(word_q[i]);
    pc_fail = (pop_cnt < CW'(ONES_MIN)) || (pop_cnt > CW'(ONES_MAX));

    if (last_ok_q && (word_q == last_word_q))
      rep_new = (rep_cnt_q >= RW'(RCT_LIMIT)) ? rep_cnt_q : rep_cnt_q + RW'(1);
    else
      rep_new = RW'(1);

    fail = test && (pc_fail || (rep_new >= RW'(RCT_LIMIT)));
    pass = test && !fail;

    state_d     = state_q;
    su_cnt_d    = su_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    last_word_d = last_word_q;
    last_ok_d   = last_ok_q;
    push        = 1'b0;
    drop        = 1'b0;
    flush       = 1'b0;
    enter_su    = 1'b0;

    if (test) begin
      rep_cnt_d   = rep_new;
      last_word_d = word_q;
      last_ok_d   = 1'b1;
    end

    unique case (state_q)
      ST_STARTUP: begin
        if (!enable_i) begin
          enter_su = 1'b1;
          flush    = 1'b1;
        end else if (fail) begin
          state_d = ST_FAIL;
          flush   = 1'b1;
        end else if (pass) begin
          su_cnt_d = su_cnt_q + SW'(1);
          if (su_cnt_d >= SW'(STARTUP_WORDS)) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!enable_i) begin
          enter_su = 1'b1;
          flush    = 1'b1;
        end else if (fail) begin
          state_d = ST_FAIL;
          flush   = 1'b1;
        end else if (pass) begin
          if (!full || pop) push = 1'b1;
          else              drop = 1'b1;
        end
      end
      ST_FAIL: begin
        if (clear_i) enter_su = 1'b1;
      end
      default: state_d = ST_FAIL;
    endcase

    if (enter_su) begin
      state_d   = ST_STARTUP;
      su_cnt_d  = '0;
      rep_cnt_d = '0;
      last_ok_d = 1'b0;
    end

    fail_cnt_d = (fail && fail_cnt_q != 8'hFF) ? fail_cnt_q + 8'd1 : fail_cnt_q;
    drop_cnt_d = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d  = level_q + LW'(push) - LW'(pop);
    end
  end

  // FSM state register
  always_ff @(posedge wb_clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_STARTUP;
    else         state_q <= state_d;
  end

  // Capture pipeline, health-test history and counters
  always_ff @(posedge wb_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q     <= 1'b0;
      pend_q      <= 1'b0;
      word_q      <= '0;
      last_word_q <= '0;
      last_ok_q   <= 1'b0;
      rep_cnt_q   <= '0;
      su_cnt_q    <= '0;
      fail_cnt_q  <= '0;
      drop_cnt_q  <= '0;
    end else begin
      valid_q     <= trng_valid_i;
      pend_q      <= pend_d;
      word_q      <= word_d;
      last_word_q <= last_word_d;
      last_ok_q   <= last_ok_d;
      rep_cnt_q   <= rep_cnt_d;
      su_cnt_q    <= su_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge wb_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // FIFO storage, reset so the head never reads X
  always_ff @(posedge wb_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= word_q;
    end
  end

  assign data_valid_o  = (level_q != '0);
  assign data_o        = mem_q[rd_ptr_q];
  assign level_o       = level_q;
  assign health_fail_o = (state_q == ST_FAIL);
  assign fail_cnt_o    = fail_cnt_q;
  assign drop_cnt_o    = drop_cnt_q;
endmodule

// File: tb/tb_trng_health_fifo.sv
// Bench for trng_health_fifo: behavioural queue model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_trng_health_fifo;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, clear, trng_valid, data_ready;
  logic [31:0] trng_word;
  logic        data_valid_o, health_fail_o;
  logic [31:0] data_o;
  logic [2:0]  level_o;
  logic [7:0]  fail_cnt_o, drop_cnt_o;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  trng_health_fifo #(
    .WORD_WIDTH(32), .FIFO_DEPTH(4), .STARTUP_WORDS(2),
    .RCT_LIMIT(3), .ONES_MIN(8), .ONES_MAX(24)
  ) dut (
    .wb_clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .clear_i(clear),
    .trng_valid_i(trng_valid), .trng_word_i(trng_word),
    .data_valid_o(data_valid_o), .data_ready_i(data_ready), .data_o(data_o),
    .level_o(level_o), .health_fail_o(health_fail_o),
    .fail_cnt_o(fail_cnt_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 = startup, 1 = run, 2 = alarm
  int          m_mode, m_rep, m_su, m_failc, m_dropc;
  bit          m_vq, m_pend, m_lastok;
  logic [31:0] m_word, m_last;
  logic [31:0] m_q[$];

  initial forever begin
    bit cap, popd, bad;
    int ones;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_mode = 0; m_rep = 0; m_su = 0; m_failc = 0; m_dropc = 0;
      m_vq = 0; m_pend = 0; m_lastok = 0; m_word = '0; m_last = '0;
      m_q.delete();
    end else begin
      cap  = enable && (m_mode != 2) && trng_valid && !m_vq;
      popd = (m_q.size() > 0) && data_ready;
      if (m_mode == 2) begin
        if (clear) begin m_mode = 0; m_su = 0; m_rep = 0; m_lastok = 0; end
      end else if (!enable) begin
        m_q.delete();
        m_mode = 0; m_su = 0; m_rep = 0; m_lastok = 0;
      end else begin
        if (popd) void'(m_q.pop_front());
        if (m_pend) begin
          ones  = $countones(m_word);
          m_rep = (m_lastok && m_word == m_last) ? ((m_rep + 1 > 3) ? 3 : m_rep + 1) : 1;
          m_last = m_word; m_lastok = 1;
          bad = (ones < 8) || (ones > 24) || (m_rep >= 3);
          if (bad) begin
            if (m_failc < 255) m_failc++;
            m_mode = 2;
            m_q.delete();
          end else if (m_mode == 0) begin
            m_su++;
            if (m_su >= 2) m_mode = 1;
          end else if (m_q.size() < 4) begin
            m_q.push_back(m_word);
          end else if (m_dropc < 255) begin
            m_dropc++;
          end
        end
      end
      m_pend = cap;
      if (cap) m_word = trng_word;
      m_vq = trng_valid;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("m_valid", data_valid_o, m_q.size() != 0);
      chk("m_level", level_o, m_q.size());
      chk("m_hfail", health_fail_o, m_mode == 2);
      chk("m_failcnt", fail_cnt_o, m_failc);
      chk("m_dropcnt", drop_cnt_o, m_dropc);
      if (m_q.size() != 0) chk("m_data", data_o, m_q[0]);
    end
  end

  // Called at a negedge; returns at the negedge after the capture edge
  task automatic present(input logic [31:0] w);
    trng_valid = 1'b1;
    trng_word  = w;
    @(negedge clk);
    trng_valid = 1'b0;
  endtask

  // Returns once the word's test/push edge has passed
  task automatic send(input logic [31:0] w);
    present(w);
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    logic [31:0] prev;
    logic [31:0] exp_w [4];
    int r;
    enable = 0; clear = 0; trng_valid = 0; trng_word = '0; data_ready = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_valid", data_valid_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_level", level_o, 0);
    chk("rst_hfail", health_fail_o, 0);
    chk("rst_failcnt", fail_cnt_o, 0);
    chk("rst_dropcnt", drop_cnt_o, 0);
    @(negedge clk); @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    enable = 1'b1;
    @(negedge clk);

    // Startup discard
    send(32'hA5A5A5A5); chk("su_disc1", level_o, 0);
    send(32'h5A5A5A5A); chk("su_disc2", level_o, 0);
    present(32'h3C3C3C3C);
    chk("su_not_yet", data_valid_o, 0);
    @(negedge clk);
    chk("su_valid", data_valid_o, 1);
    chk("su_data", data_o, 32'h3C3C3C3C);
    chk("su_level", level_o, 1);

    // Popcount bound
    send(32'h00000001);
    chk("pc_hfail", health_fail_o, 1);
    chk("pc_failcnt", fail_cnt_o, 1);
    chk("pc_level", level_o, 0);
    send(32'h0F0F0F0F);
    chk("pc_ignored", level_o, 0);
    chk("pc_still", health_fail_o, 1);
    pulse_clear();
    chk("pc_cleared", health_fail_o, 0);

    // Popcount exactly at both bounds passes; repetition fails on the third
    send(32'h000000FF); send(32'hFFFFFF00);
    send(32'h12345678); chk("rct_l1", level_o, 1);
    send(32'h12345678); chk("rct_l2", level_o, 2);
    send(32'h12345678);
    chk("rct_hfail", health_fail_o, 1);
    chk("rct_level", level_o, 0);
    chk("rct_failcnt", fail_cnt_o, 2);
    pulse_clear();

    // Popcount one above max fails even during startup
    send(32'h01FFFFFF);
    chk("pcmax_hfail", health_fail_o, 1);
    chk("pcmax_failcnt", fail_cnt_o, 3);
    pulse_clear();
    send(32'hA5A5A5A5); send(32'h5A5A5A5A);

    // Full / drop
    data_ready = 0;
    for (int k = 1; k <= 6; k++) send(32'h5A5A5A00 | k);
    chk("full_level", level_o, 4);
    chk("full_drop", drop_cnt_o, 2);

    // Push and pop together while full
    present(32'h3C3C3C3C);
    data_ready = 1;
    @(negedge clk);
    data_ready = 0;
    chk("pp_level", level_o, 4);
    chk("pp_drop", drop_cnt_o, 2);
    exp_w[0] = 32'h5A5A5A02; exp_w[1] = 32'h5A5A5A03;
    exp_w[2] = 32'h5A5A5A04; exp_w[3] = 32'h3C3C3C3C;
    data_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", data_o, exp_w[i]);
      @(negedge clk);
    end
    data_ready = 0;
    chk("drain_empty", level_o, 0);

    // Enable loss and asynchronous reset
    send(32'h0F0F0F0F); send(32'hF0F0F0F0);
    chk("en_level2", level_o, 2);
    enable = 0;
    @(negedge clk);
    chk("en_flush", level_o, 0);
    enable = 1;
    send(32'hA5A5A5A5); send(32'h5A5A5A5A);
    send(32'h3C3C3C3C);
    chk("en_restart", level_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", data_valid_o, 0);
    chk("ar_data", data_o, 0);
    chk("ar_level", level_o, 0);
    chk("ar_failcnt", fail_cnt_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized traffic
    prev = 32'h3C3C3C3C;
    for (int c = 0; c < 4000; c++) begin
      r = $urandom_range(0, 99);
      if (r < 8)       trng_word = $urandom & 32'h00000F0F;
      else if (r < 22) trng_word = prev;
      else             trng_word = $urandom;
      prev       = trng_word;
      trng_valid = $urandom_range(0, 1) == 1;
      data_ready = $urandom_range(0, 5) == 0;
      clear      = $urandom_range(0, 15) == 0;
      enable     = $urandom_range(0, 63) != 0;
      @(negedge clk);
    end
    trng_valid = 0; clear = 0; enable = 1; data_ready = 1;
    repeat (8) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
